// File: rtl/pulse_blinker_pkg.sv
// Shared types and helpers for the pulse_blinker LED blink generator.
// Holds the blink FSM state type and the dwell-timer width calculation.
// Import with: import pulse_blinker_pkg::*;
package pulse_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_t;

  // Timer must count 0..max(on,off)-1. A one-cycle dwell would give a
  // zero-width timer, so the width is floored at one bit.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int m;
    m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter holding the number of queued blink requests.
// Ports: clk, rst (async, active-high), inc, dec -> count, drop.
// Latency: count updates on the clock after inc/dec; drop is a registered
// one-cycle pulse in the cycle after an increment was refused at MAX.
module sat_updown_counter #(
  parameter int MAX = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(MAX+1)-1:0]   count,
  output logic                       drop
);

  localparam int W = $clog2(MAX + 1);

  logic full;
  assign full = (count == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      drop  <= 1'b0;
    end else begin
      // inc and dec together cancel, including at zero (the incoming request
      // is consumed directly) and at MAX (a slot frees as one arrives).
      drop <= inc && !dec && full;
      if (inc && !dec && !full) begin
        count <= count + W'(1);
      end else if (dec && !inc && (count != '0)) begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_blinker.sv
// Turns single-cycle event pulses into human-visible LED blinks: each event
// yields ON_CYCLES of LED on then at least OFF_CYCLES off; events arriving
// mid-blink queue in a saturating counter (excess events flagged on overflow).
// Ports: clk, rst (async, active-high), event_pulse -> led, busy, pending, overflow.
// Build option: define LED_ACTIVE_LOW_EN to drive led low while ON.
module pulse_blinker
  import pulse_blinker_pkg::*;
#(
  parameter int ON_CYCLES   = 15,
  parameter int OFF_CYCLES  = 15,
  parameter int MAX_PENDING = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               event_pulse,
  output logic                               led,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  blink_state_t  state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          start;
  logic          request;
  logic          led_on;

  // A request is either something already queued or an event this cycle.
  assign request = (pending != '0) || event_pulse;
  assign start    = ((state_q == IDLE) ||
                     ((state_q == GAP) && (timer_q == OFF_LAST))) && request;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ON;
      ON:   if (timer_q == ON_LAST) state_d = GAP;
      GAP: begin
        if (start)                      state_d = ON;
        else if (timer_q == OFF_LAST)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer free-runs and restarts on every state change; only its value in
  // ON and GAP matters, so wrapping while IDLE is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_d != state_q) ? '0 : timer_q + TW'(1);
    end
  end

  sat_updown_counter #(
    .MAX (MAX_PENDING)
  ) u_pending (
    .clk   (clk),
    .rst   (rst),
    .inc   (event_pulse),
    .dec   (start),
    .count (pending),
    .drop  (overflow)
  );

  // Outputs decode straight from the state register: no input-to-pin path.
  assign led_on = (state_q == ON);
  assign busy   = (state_q != IDLE);

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_on;
`else
  assign led = led_on;
`endif

endmodule

// File: tb/tb_pulse_blinker.sv
module tb_pulse_blinker;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int MAXP  = 2;
`ifdef LED_ACTIVE_LOW_EN
  localparam int ACT_LOW = 1;
`else
  localparam int ACT_LOW = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       event_pulse = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: blinks expressed as absolute start times.
  int cyc;        // cycle index of the next output check
  int last_s;     // first led-on cycle of the most recent blink
  int pend_m;     // queued requests
  int ovf_m;      // overflow expected in the next checked cycle

  pulse_blinker #(
    .ON_CYCLES   (ON_C),
    .OFF_CYCLES  (OFF_C),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .event_pulse (event_pulse),
    .led         (led),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    last_s = -1000;
    pend_m = 0;
    ovf_m  = 0;
  endtask

  // Decide what cycle c with event e does: a blink may begin at c+1 only once
  // the previous blink's ON window and full gap are over.
  task automatic model_step(input int c, input int e);
    ovf_m = 0;
    if ((c + 1 >= last_s + ON_C + OFF_C) && (pend_m > 0 || e != 0)) begin
      last_s = c + 1;
      pend_m = pend_m + e - 1;
    end else if (e != 0) begin
      if (pend_m == MAXP) ovf_m = 1;
      else                pend_m++;
    end
  endtask

  task automatic check_outputs();
    int on_exp;
    int busy_exp;
    on_exp   = (cyc >= last_s && cyc < last_s + ON_C) ? 1 : 0;
    busy_exp = (cyc < last_s + ON_C + OFF_C) ? 1 : 0;
    check("led",      int'(led),      on_exp ^ ACT_LOW);
    check("busy",     int'(busy),     busy_exp);
    check("pending",  int'(pending),  pend_m);
    check("overflow", int'(overflow), ovf_m);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_led"},      int'(led),      ACT_LOW);
    check({tag, "_busy"},     int'(busy),     0);
    check({tag, "_pending"},  int'(pending),  0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // One clock: check the current cycle, then present this cycle's event.
  task automatic drive_cycle(input int e);
    @(negedge clk);
    check_outputs();
    event_pulse = (e != 0);
    model_step(cyc, e);
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0);
  endtask

  // Assert reset between edges and confirm outputs drop before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    event_pulse = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    @(posedge clk);
    @(negedge clk);
    check_reset_values({tag, "_held"});
    rst = 1'b0;
    model_reset();
    cyc += 2;
    model_step(cyc, 0);
    cyc++;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;
    model_step(cyc, 0);
    cyc++;

    // Single pulse
    idle_cycles(3);
    drive_cycle(1);
    idle_cycles(12);

    // Burst of three
    drive_cycle(1); drive_cycle(1); drive_cycle(1);
    idle_cycles(25);

    // Overflow: fourth event dropped
    for (int i = 0; i < 4; i++) drive_cycle(1);
    idle_cycles(25);

    // Request landing in the final gap cycle
    drive_cycle(1);
    idle_cycles(6);
    drive_cycle(1);
    idle_cycles(12);

    // Reset mid-blink with two queued, then a fresh blink
    drive_cycle(1); drive_cycle(1); drive_cycle(1);
    idle_cycles(1);
    async_reset("rst_mid");
    idle_cycles(2);
    drive_cycle(1);
    idle_cycles(10);

    // Randomized traffic with varying density and occasional resets
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = $urandom_range(1, 9);
      for (int i = 0; i < 60; i++) begin
        drive_cycle(($urandom_range(0, 9) < dens) ? 1 : 0);
      end
      if ($urandom_range(0, 3) == 0) async_reset("rst_rand");
    end
    idle_cycles(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
